cola_de_instrucciones: RTL and testbench
========================================

# cola_de_instrucciones

Parametrised instruction register with a prefetch queue. It sits between program memory fetch and the control unit of the UAZ micro. It buffers up to DEPTH fetched instruction words under a valid/ready handshake. It presents the oldest word split into opcode, operand and extended-immediate fields, and releases that word only when the control unit advances.

## Interface
Parameters:
- OPCODE_W, 3, opcode field width.
- OPERAND_W, 6, operand field width; instruction word width W = OPCODE_W + OPERAND_W.
- IMM_W, 8, immediate output width.
- DEPTH, 4, queue entries (≥1, any integer, not restricted to a power of two).
- SIGN_EXT, 0, 0 = zero-extend operand to immediate, 1 = sign-extend.

Ports:
- i_Timming  in  1  clock, rising edge.
- i_Rst  in  1  reset; asynchronous, active-low.
- i_Flush  in  1  synchronous queue clear (branch/jump).
- i_Valido  in  1  fetch word on i_Instrucciones is valid.
- o_Listo  out  1  queue can accept a word (not full).
- i_Instrucciones  in  W  fetched instruction word.
- i_Avanzar  in  1  control unit consumes the current instruction.
- o_Valido  out  1  current instruction fields are valid.
- o_Instruccion  out  OPCODE_W  opcode = head[W-1 -: OPCODE_W].
- o_Operandos  out  OPERAND_W  operands = head[OPERAND_W-1:0].
- o_Direccionamiento_inmediato  out  IMM_W  operand field extended/truncated to IMM_W.
- o_Ocupacion  out  $clog2(DEPTH+1)  stored entries, head included.

## Operation
- Push: i_Valido && o_Listo at the rising edge. Word written at the write pointer; count +1.
- Pop: i_Avanzar && o_Valido at the rising edge. Read pointer advances; count −1.
- i_Avanzar while o_Valido=0 is ignored. i_Valido while o_Listo=0 is ignored; the word is dropped and the source must hold it.
- Simultaneous push and pop when 0 < count < DEPTH: both occur; count unchanged.
- o_Listo = (count != DEPTH). It depends only on registered state; a pop in the same cycle does not open a slot.
- o_Valido = (count != 0).
- Pointers wrap from DEPTH-1 to 0.
- Flush has priority: count and both pointers go to 0, and any push or pop in that cycle is discarded.
- Immediate: if IMM_W > OPERAND_W, the upper bits are zeros (SIGN_EXT=0) or copies of operand MSB (SIGN_EXT=1). If IMM_W ≤ OPERAND_W, it is operand[IMM_W-1:0].
- Field outputs are combinational decodes of the head storage entry only. There is no combinational path from any input to any output.
- When o_Valido=0, field outputs are forced to 0.

## Timing
- Reset (i_Rst=0) acts immediately, independent of clock. Count, pointers and storage clear. Outputs: o_Valido=0, o_Listo=1, o_Ocupacion=0, all field outputs 0.
- Reset asserted mid-operation discards all queued words. The first accepted push after release is the new head.
- Latency: a word pushed into an empty queue appears on the field outputs with o_Valido=1 after that same edge, i.e. one cycle later.
- Push and pop complete in one edge each. There are no stall cycles.
- After a pop, the next entry (if any) is presented immediately after the same edge.
- After flush, o_Valido=0 and o_Listo=1 from the next edge.

## Structure
- Package cola_de_instrucciones_pkg holds:
  - default width constants (OPCODE_W, OPERAND_W, IMM_W, DEPTH);
  - opcode localparams for the 3-bit ISA;
  - a function for the immediate extension.
- One sub-module: fifo_sincrona, a generic W×DEPTH register-array FIFO. It provides pointers, count, full/empty and flush.
- The top level adds the handshake gating, field decode and immediate extension.

## Test plan
Defaults used unless noted.

1. Reset: hold i_Rst=0 with i_Valido=1 and clocks running. Required: o_Valido=0, o_Listo=1, o_Ocupacion=0 and fields 0 throughout. Release reset; state unchanged until the first push.
2. Single word: push 9'b111001110. After the edge: o_Valido=1, o_Instruccion=3'b111, o_Operandos=6'b001110, immediate 8'h0E. Pop; then o_Valido=0.
3. Sign extension: with SIGN_EXT=1, push 9'b000110110. Required: o_Operandos=6'b110110, immediate 8'hF6. With SIGN_EXT=0, immediate 8'h36.
4. Fill and order: push 9'b011001100, 9'b010001110, 9'b100001111, 9'b000110110. Required: o_Ocupacion=4, o_Listo=0. A 5th push of 9'b001110110 is dropped. Pop four times; opcodes appear in order 011, 010, 100, 000.
5. Simultaneous push/pop: at count=2, assert both for 3 cycles. Required: count stays 2 and FIFO order is preserved. At count=4, assert both: the pop occurs, the push is dropped, count=3.
6. Flush: queue 3 words, then assert i_Flush together with i_Valido and i_Avanzar. Required next cycle: o_Ocupacion=0, o_Valido=0, o_Listo=1. Async reset mid-fill gives the same result immediately.

Source files
------------

// File: rtl/cola_de_instrucciones_pkg.sv
// Shared constants and helpers for the UAZ instruction queue: default widths,
// the 3-bit opcode map and the operand-to-immediate extension.
package cola_de_instrucciones_pkg;

   localparam int DEF_OPCODE_W  = 3;
   localparam int DEF_OPERAND_W = 6;
   localparam int DEF_IMM_W     = 8;
   localparam int DEF_DEPTH     = 4;

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_AND   = 3'b100;
   localparam logic [2:0] OP_OR    = 3'b101;
   localparam logic [2:0] OP_JMP   = 3'b110;
   localparam logic [2:0] OP_JZ    = 3'b111;

   // Works on a 32-bit container; the caller slices the low IMM_W bits, which
   // also covers the truncating case IMM_W <= operand_w.
   function automatic logic [31:0] extender(input logic [31:0] operand,
                                            input int          operand_w,
                                            input logic        sign_ext);
      logic [31:0] mask;
      logic [31:0] shifted;
      mask    = (operand_w >= 32) ? '1 : ((32'd1 << operand_w) - 32'd1);
      shifted = operand >> (operand_w - 1);
      return (operand & mask) | ((sign_ext && shifted[0]) ? ~mask : '0);
   endfunction

endpackage

// File: rtl/cola_de_instrucciones_fifo_sincrona.sv
// Generic W x DEPTH register-array FIFO with wrap-around pointers, occupancy
// count and a synchronous flush that overrides push and pop.
module fifo_sincrona
   import cola_de_instrucciones_pkg::*;
#(
   parameter  int W     = DEF_OPCODE_W + DEF_OPERAND_W,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Explicit compare instead of a modulo so any DEPTH wraps correctly.
   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = inc_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = inc_ptr(rd_ptr_q);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/cola_de_instrucciones.sv
// Prefetch instruction queue for the UAZ micro: buffers fetched words and
// presents the oldest one decoded into opcode, operand and immediate fields.
module cola_de_instrucciones
   import cola_de_instrucciones_pkg::*;
#(
   parameter int OPCODE_W  = DEF_OPCODE_W,
   parameter int OPERAND_W = DEF_OPERAND_W,
   parameter int IMM_W     = DEF_IMM_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int SIGN_EXT  = 0
) (
   input  logic                           i_Timming,
   input  logic                           i_Rst,
   input  logic                           i_Flush,
   input  logic                           i_Valido,
   output logic                           o_Listo,
   input  logic [OPCODE_W+OPERAND_W-1:0]  i_Instrucciones,
   input  logic                           i_Avanzar,
   output logic                           o_Valido,
   output logic [OPCODE_W-1:0]            o_Instruccion,
   output logic [OPERAND_W-1:0]           o_Operandos,
   output logic [IMM_W-1:0]               o_Direccionamiento_inmediato,
   output logic [$clog2(DEPTH+1)-1:0]     o_Ocupacion
);

   localparam int W     = OPCODE_W + OPERAND_W;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     head;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [31:0]      imm_ext;

   // Handshake gating uses only registered full/empty, so a same-cycle pop
   // never opens a slot for a push.
   assign push = i_Valido && !full;
   assign pop  = i_Avanzar && !empty;

   fifo_sincrona #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_Timming),
      .rst_n (i_Rst),
      .flush (i_Flush),
      .push  (push),
      .pop   (pop),
      .din   (i_Instrucciones),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign imm_ext = extender(32'(head[OPERAND_W-1:0]), OPERAND_W, SIGN_EXT != 0);

   always_comb begin
      o_Instruccion                = '0;
      o_Operandos                  = '0;
      o_Direccionamiento_inmediato = '0;
      if (!empty) begin
         o_Instruccion                = head[W-1 -: OPCODE_W];
         o_Operandos                  = head[OPERAND_W-1:0];
         o_Direccionamiento_inmediato = imm_ext[IMM_W-1:0];
      end
   end

   assign o_Listo     = !full;
   assign o_Valido    = !empty;
   assign o_Ocupacion = count;

endmodule

// File: tb/tb_cola_de_instrucciones.sv
// Directed bench for cola_de_instrucciones; a zero-extending and a
// sign-extending instance share the same stimulus.
module tb_cola_de_instrucciones;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       valido;
   logic       avanzar;
   logic [8:0] instr;

   logic       listo_z, valido_z, listo_s, valido_s;
   logic [2:0] op_z, op_s, ocup_z, ocup_s;
   logic [5:0] opr_z, opr_s;
   logic [7:0] imm_z, imm_s;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cola_de_instrucciones #(.SIGN_EXT(0)) u_dut_z (
      .i_Timming                    (clk),
      .i_Rst                        (rst_n),
      .i_Flush                      (flush),
      .i_Valido                     (valido),
      .o_Listo                      (listo_z),
      .i_Instrucciones              (instr),
      .i_Avanzar                    (avanzar),
      .o_Valido                     (valido_z),
      .o_Instruccion                (op_z),
      .o_Operandos                  (opr_z),
      .o_Direccionamiento_inmediato (imm_z),
      .o_Ocupacion                  (ocup_z)
   );

   cola_de_instrucciones #(.SIGN_EXT(1)) u_dut_s (
      .i_Timming                    (clk),
      .i_Rst                        (rst_n),
      .i_Flush                      (flush),
      .i_Valido                     (valido),
      .o_Listo                      (listo_s),
      .i_Instrucciones              (instr),
      .i_Avanzar                    (avanzar),
      .o_Valido                     (valido_s),
      .o_Instruccion                (op_s),
      .o_Operandos                  (opr_s),
      .o_Direccionamiento_inmediato (imm_s),
      .o_Ocupacion                  (ocup_s)
   );

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic v, input logic [8:0] w, input logic a, input logic f);
      valido  = v;
      instr   = w;
      avanzar = a;
      flush   = f;
      @(posedge clk);
      #1;
      $display("txn: valido=%0b word=%09b avanzar=%0b flush=%0b -> ocup=%0d valid=%0b listo=%0b op=%03b opr=%06b",
               v, w, a, f, ocup_z, valido_z, listo_z, op_z, opr_z);
      valido  = 1'b0;
      avanzar = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      valido = 1'b1;
      instr  = 9'h1FF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (valido_z !== 1'b0 || listo_z !== 1'b1 || ocup_z !== 3'd0 ||
             op_z !== 3'd0 || opr_z !== 6'd0 || imm_z !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold: valid=%0b listo=%0b ocup=%0d op=%0h opr=%0h imm=%0h expected 0 1 0 0 0 0",
                     valido_z, listo_z, ocup_z, op_z, opr_z, imm_z);
         end
      end
      rst_n  = 1'b1;
      valido = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (valido_z !== 1'b0 || listo_z !== 1'b1 || ocup_z !== 3'd0) begin
         failures++;
         $display("FAIL reset_release: valid=%0b listo=%0b ocup=%0d expected 0 1 0", valido_z, listo_z, ocup_z);
      end
   endtask

   task automatic test_single_word();
      step(1'b1, 9'b111001110, 1'b0, 1'b0);
      checks++;
      if (valido_z !== 1'b1 || op_z !== 3'b111 || opr_z !== 6'b001110 || imm_z !== 8'h0E || ocup_z !== 3'd1) begin
         failures++;
         $display("FAIL single_push: valid=%0b op=%03b opr=%06b imm=%02h ocup=%0d expected 1 111 001110 0e 1",
                  valido_z, op_z, opr_z, imm_z, ocup_z);
      end
      step(1'b0, 9'd0, 1'b1, 1'b0);
      checks++;
      if (valido_z !== 1'b0 || op_z !== 3'd0 || opr_z !== 6'd0 || imm_z !== 8'd0 || ocup_z !== 3'd0) begin
         failures++;
         $display("FAIL single_pop: valid=%0b op=%0h opr=%0h imm=%0h ocup=%0d expected all 0",
                  valido_z, op_z, opr_z, imm_z, ocup_z);
      end
   endtask

   task automatic test_sign_ext();
      step(1'b1, 9'b000110110, 1'b0, 1'b0);
      checks++;
      if (opr_s !== 6'b110110 || imm_s !== 8'hF6) begin
         failures++;
         $display("FAIL sign_ext: opr=%06b imm=%02h expected 110110 f6", opr_s, imm_s);
      end
      checks++;
      if (opr_z !== 6'b110110 || imm_z !== 8'h36) begin
         failures++;
         $display("FAIL zero_ext: opr=%06b imm=%02h expected 110110 36", opr_z, imm_z);
      end
      step(1'b0, 9'd0, 1'b1, 1'b0);
      checks++;
      if (valido_s !== 1'b0 || imm_s !== 8'd0) begin
         failures++;
         $display("FAIL sign_ext_pop: valid=%0b imm=%02h expected 0 00", valido_s, imm_s);
      end
   endtask

   task automatic test_fill_order();
      logic [8:0] words [4];
      logic [2:0] ops   [4];
      words = '{9'b011001100, 9'b010001110, 9'b100001111, 9'b000110110};
      ops   = '{3'b011, 3'b010, 3'b100, 3'b000};
      for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
      checks++;
      if (ocup_z !== 3'd4 || listo_z !== 1'b0) begin
         failures++;
         $display("FAIL fill_full: ocup=%0d listo=%0b expected 4 0", ocup_z, listo_z);
      end
      step(1'b1, 9'b001110110, 1'b0, 1'b0);
      checks++;
      if (ocup_z !== 3'd4 || op_z !== 3'b011) begin
         failures++;
         $display("FAIL fill_drop: ocup=%0d head_op=%03b expected 4 011", ocup_z, op_z);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (op_z !== ops[i] || valido_z !== 1'b1) begin
            failures++;
            $display("FAIL fill_order[%0d]: op=%03b valid=%0b expected %03b 1", i, op_z, valido_z, ops[i]);
         end
         step(1'b0, 9'd0, 1'b1, 1'b0);
      end
      checks++;
      if (valido_z !== 1'b0 || ocup_z !== 3'd0 || listo_z !== 1'b1) begin
         failures++;
         $display("FAIL fill_drain: valid=%0b ocup=%0d listo=%0b expected 0 0 1", valido_z, ocup_z, listo_z);
      end
   endtask

   task automatic test_push_pop();
      logic [8:0] words [8];
      logic [2:0] heads [3];
      words = '{9'b001000001, 9'b010000010, 9'b011000011, 9'b100000100,
                9'b101000101, 9'b110000110, 9'b111000111, 9'b000001000};
      heads = '{3'b010, 3'b011, 3'b100};
      step(1'b1, words[0], 1'b0, 1'b0);
      step(1'b1, words[1], 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, words[2+i], 1'b1, 1'b0);
         checks++;
         if (ocup_z !== 3'd2 || op_z !== heads[i]) begin
            failures++;
            $display("FAIL push_pop[%0d]: ocup=%0d op=%03b expected 2 %03b", i, ocup_z, op_z, heads[i]);
         end
      end
      step(1'b1, words[5], 1'b0, 1'b0);
      step(1'b1, words[6], 1'b0, 1'b0);
      step(1'b1, words[7], 1'b1, 1'b0);
      checks++;
      if (ocup_z !== 3'd3 || op_z !== 3'b101 || listo_z !== 1'b1) begin
         failures++;
         $display("FAIL push_pop_full: ocup=%0d op=%03b listo=%0b expected 3 101 1", ocup_z, op_z, listo_z);
      end
      step(1'b0, 9'd0, 1'b1, 1'b0);
      step(1'b0, 9'd0, 1'b1, 1'b0);
      checks++;
      if (ocup_z !== 3'd1 || op_z !== 3'b111 || opr_z !== 6'b000111) begin
         failures++;
         $display("FAIL push_pop_tail: ocup=%0d op=%03b opr=%06b expected 1 111 000111", ocup_z, op_z, opr_z);
      end
      step(1'b0, 9'd0, 1'b1, 1'b0);
      checks++;
      if (valido_z !== 1'b0 || ocup_z !== 3'd0) begin
         failures++;
         $display("FAIL push_pop_empty: valid=%0b ocup=%0d expected 0 0", valido_z, ocup_z);
      end
   endtask

   task automatic test_flush();
      step(1'b1, 9'b011000001, 1'b0, 1'b0);
      step(1'b1, 9'b100000010, 1'b0, 1'b0);
      step(1'b1, 9'b101000011, 1'b0, 1'b0);
      step(1'b1, 9'b110000100, 1'b1, 1'b1);
      checks++;
      if (ocup_z !== 3'd0 || valido_z !== 1'b0 || listo_z !== 1'b1 || op_z !== 3'd0) begin
         failures++;
         $display("FAIL flush: ocup=%0d valid=%0b listo=%0b op=%03b expected 0 0 1 000", ocup_z, valido_z, listo_z, op_z);
      end
      step(1'b1, 9'b010101010, 1'b0, 1'b0);
      checks++;
      if (ocup_z !== 3'd1 || op_z !== 3'b010 || opr_z !== 6'b101010) begin
         failures++;
         $display("FAIL flush_refill: ocup=%0d op=%03b opr=%06b expected 1 010 101010", ocup_z, op_z, opr_z);
      end
      step(1'b0, 9'd0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      step(1'b1, 9'b111111111, 1'b0, 1'b0);
      step(1'b1, 9'b110110110, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (ocup_z !== 3'd0 || valido_z !== 1'b0 || listo_z !== 1'b1 || op_z !== 3'd0) begin
         failures++;
         $display("FAIL async_reset: ocup=%0d valid=%0b listo=%0b op=%03b expected 0 0 1 000", ocup_z, valido_z, listo_z, op_z);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 9'b001011011, 1'b0, 1'b0);
      checks++;
      if (ocup_z !== 3'd1 || op_z !== 3'b001 || opr_z !== 6'b011011 || imm_z !== 8'h1B) begin
         failures++;
         $display("FAIL async_reset_head: ocup=%0d op=%03b opr=%06b imm=%02h expected 1 001 011011 1b",
                  ocup_z, op_z, opr_z, imm_z);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      valido  = 1'b0;
      avanzar = 1'b0;
      instr   = '0;
      #2;
      test_reset();
      test_single_word();
      test_sign_ext();
      test_fill_order();
      test_push_pop();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
